// File: rtl/pixel_decoder_if.sv
// Raster input (ce/hs/vs/de) and decoded coordinate/lock outputs of pixel_decoder.
// master = raster source side, slave = the decoder.
interface pixel_decoder_if #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480
);
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);

    logic               ce;
    logic               hs;
    logic               vs;
    logic               de;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               de_o;
    logic               frame_start;
    logic               locked;
    logic               error;
    logic [X_WIDTH:0]   measured_width;
    logic [Y_WIDTH:0]   measured_height;

    modport master (
        output ce, hs, vs, de,
        input  x, y, de_o, frame_start, locked, error, measured_width, measured_height
    );

    modport slave (
        input  ce, hs, vs, de,
        output x, y, de_o, frame_start, locked, error, measured_width, measured_height
    );
endinterface

// File: rtl/pixel_decoder.sv
// Recovers x/y pixel coordinates and geometry lock from a raw hs/vs/de raster.
// Optional run/line measurement outputs are built when PIXEL_DECODER_MEASURE_EN is defined.
module pixel_decoder #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter bit HOR_SYNC_POLARITY = 1'b0,
    parameter bit VER_SYNC_POLARITY = 1'b0,
    parameter int LOCK_FRAMES       = 2
) (
    input logic            clk_rgb,
    input logic            rst_n,
    pixel_decoder_if.slave bus
);
    localparam int X_WIDTH   = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH   = $clog2(VER_ACTIVE_PIXELS);
    localparam int CNT_WIDTH = $clog2(LOCK_FRAMES + 1);

    localparam logic [X_WIDTH-1:0]   X_MAX       = X_WIDTH'(HOR_ACTIVE_PIXELS - 1);
    localparam logic [X_WIDTH:0]     RUN_MAX     = '1;
    localparam logic [X_WIDTH:0]     RUN_TARGET  = (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH-1:0]   Y_MAX       = '1;
    localparam logic [Y_WIDTH:0]     LINE_MAX    = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS + 1);
    localparam logic [Y_WIDTH:0]     LINE_TARGET = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS);
    localparam logic [CNT_WIDTH-1:0] GOOD_LAST   = CNT_WIDTH'(LOCK_FRAMES - 1);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic                 vs_a, hs_a, vs_q, de_q;
    logic                 vs_edge, de_fall;
    logic [X_WIDTH-1:0]   x;
    logic [Y_WIDTH-1:0]   y, y_line;
    logic                 de_o;
    logic [X_WIDTH:0]     run_len;
    logic [Y_WIDTH:0]     line_idx, line_idx_inc;
    logic                 line_err, line_err_nxt, frame_ok;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] good_cnt;
    logic                 locked, frame_start, error;
    logic                 unused_hs;

    assign vs_a      = (bus.vs == VER_SYNC_POLARITY);
    assign hs_a      = (bus.hs == HOR_SYNC_POLARITY);
    assign unused_hs = hs_a;

    assign vs_edge = bus.ce & vs_a & ~vs_q;
    assign de_fall = bus.ce & ~bus.de & de_q;

    // A line that ends on the vs-edge cycle still belongs to the frame being checked.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        line_idx_inc = line_idx;
        if (de_fall && line_idx != LINE_MAX)
            line_idx_inc = line_idx + 1'b1;
    end

    assign line_err_nxt = line_err | (de_fall & (run_len != RUN_TARGET));
    assign frame_ok     = ~line_err_nxt & (line_idx_inc == LINE_TARGET);

    // Clamp into y's range once a malformed frame overruns the active line count.
    always_comb begin
        y_line = line_idx[Y_WIDTH-1:0];
        if (line_idx > {1'b0, Y_MAX})
            y_line = Y_MAX;
    end

    always_ff @(posedge clk_rgb or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            vs_q <= 1'b0;
            de_q <= 1'b0;
        end else if (bus.ce) begin
            vs_q <= vs_a;
            de_q <= bus.de;
        end
    end

    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            de_o    <= 1'b0;
            run_len <= '0;
        end else if (bus.ce) begin
            de_o <= bus.de & (state != SEARCH);
            if (bus.de) begin
                if (!de_q) begin
                    x       <= '0;
                    run_len <= (X_WIDTH + 1)'(1);
                end else begin
                    if (x != X_MAX)
                        x <= x + 1'b1;
                    if (run_len != RUN_MAX)
                        run_len <= run_len + 1'b1;
                end
                y <= vs_edge ? '0 : y_line;
            end
        end
    end

    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            line_idx <= '0;
            line_err <= 1'b0;
        end else if (vs_edge) begin
            line_idx <= '0;
            line_err <= 1'b0;
        end else begin
            line_idx <= line_idx_inc;
            line_err <= line_err_nxt;
        end
    end

    // Pulses clear on the next clock whether or not ce is high.
    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            good_cnt    <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            error       <= 1'b0;
        end else begin
            frame_start <= vs_edge;
            error       <= 1'b0;
            if (vs_edge) begin
                case (state)
                    SEARCH: begin
                        state    <= TRACK;
                        good_cnt <= '0;
                    end
                    TRACK: begin
                        if (!frame_ok) begin
                            good_cnt <= '0;
                            error    <= 1'b1;
                        end else if (good_cnt == GOOD_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!frame_ok) begin
                            state    <= TRACK;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            error    <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PIXEL_DECODER_MEASURE_EN
    logic [X_WIDTH:0] width_q;
    logic [Y_WIDTH:0] height_q;

    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            width_q  <= '0;
            height_q <= '0;
        end else begin
            if (de_fall)
                width_q <= run_len;
            if (vs_edge && state != SEARCH)
                height_q <= line_idx_inc;
        end
    end

    assign bus.measured_width  = width_q;
    assign bus.measured_height = height_q;
`else
    assign bus.measured_width  = '0;
    assign bus.measured_height = '0;
`endif

    assign bus.x           = x;
    assign bus.y           = y;
    assign bus.de_o        = de_o;
    assign bus.frame_start = frame_start;
    assign bus.locked      = locked;
    assign bus.error       = error;
endmodule

// File: tb/tb_pixel_decoder.sv
// Self-checking bench for pixel_decoder: directed raster scenarios plus randomized
// frames, all compared cycle by cycle against a frame-level reference model.
module tb_pixel_decoder;
    localparam int H    = 4;
    localparam int V    = 3;
    localparam int LOCK = 2;
    localparam int XW   = $clog2(H);
    localparam int YW   = $clog2(V);
`ifdef PIXEL_DECODER_MEASURE_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic clk_rgb = 1'b0;
    logic rst_n   = 1'b1;
    always #5 clk_rgb = ~clk_rgb;

    pixel_decoder_if #(.HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V)) bus ();

    pixel_decoder #(
        .HOR_ACTIVE_PIXELS(H),
        .VER_ACTIVE_PIXELS(V),
        .HOR_SYNC_POLARITY(1'b0),
        .VER_SYNC_POLARITY(1'b0),
        .LOCK_FRAMES(LOCK)
    ) dut (
        .clk_rgb(clk_rgb),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int gate_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the frame is a queue of completed DE-run lengths.
    bit m_vs_prev, m_de_prev, m_search, m_locked;
    int m_run, m_good;
    int m_runs[$];
    int e_x, e_y, e_de, e_fs, e_lk, e_err, e_mw, e_mh;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_vs_prev = 0; m_de_prev = 0; m_search = 1; m_locked = 0;
        m_run = 0; m_good = 0;
        m_runs.delete();
        e_x = 0; e_y = 0; e_de = 0; e_fs = 0; e_lk = 0; e_err = 0; e_mw = 0; e_mh = 0;
    endtask

    task automatic model_step(input bit ce, input bit vs, input bit de);
        bit vs_a, vs_edge, de_fall, ok;
        e_fs  = 0;
        e_err = 0;
        if (ce) begin
            vs_a    = (vs == 1'b0);
            vs_edge = vs_a && !m_vs_prev;
            de_fall = !de && m_de_prev;
            if (de_fall) begin
                m_runs.push_back(m_run);
                if (MEAS) e_mw = imin(m_run, 2 ** (XW + 1) - 1);
            end
            e_de = (de && !m_search) ? 1 : 0;
            if (de) begin
                m_run = m_de_prev ? m_run + 1 : 1;
                e_x   = imin(m_run - 1, H - 1);
                e_y   = vs_edge ? 0 : imin(m_runs.size(), 2 ** YW - 1);
            end
            if (vs_edge) begin
                ok = (m_runs.size() == V);
                foreach (m_runs[i]) if (m_runs[i] != H) ok = 0;
                e_fs = 1;
                if (m_search) begin
                    m_search = 0;
                    m_good   = 0;
                end else begin
                    if (MEAS) e_mh = imin(m_runs.size(), V + 1);
                    if (!ok) begin
                        e_err    = 1;
                        m_locked = 0;
                        m_good   = 0;
                    end else if (!m_locked) begin
                        m_good++;
                        if (m_good == LOCK) m_locked = 1;
                    end
                end
                m_runs.delete();
            end
            m_vs_prev = vs_a;
            m_de_prev = de;
            e_lk = m_locked ? 1 : 0;
        end
    endtask

    task automatic check_outputs(input string when_);
        check({when_, ".x"},           bus.x,               e_x);
        check({when_, ".y"},           bus.y,               e_y);
        check({when_, ".de_o"},        bus.de_o,            e_de);
        check({when_, ".frame_start"}, bus.frame_start,     e_fs);
        check({when_, ".locked"},      bus.locked,          e_lk);
        check({when_, ".error"},       bus.error,           e_err);
        check({when_, ".meas_w"},      bus.measured_width,  e_mw);
        check({when_, ".meas_h"},      bus.measured_height, e_mh);
    endtask

    task automatic step(input bit ce, input bit vs, input bit de);
        @(negedge clk_rgb);
        bus.ce = ce;
        bus.vs = vs;
        bus.de = de;
        bus.hs = 1'($urandom_range(0, 1));
        model_step(ce, vs, de);
        @(posedge clk_rgb);
        #1;
        check_outputs(ce ? "cyc" : "hold");
    endtask

    // One sampled pixel, optionally preceded by ce=0 cycles carrying noise.
    task automatic px(input bit vs, input bit de);
        if (gate_mode == 1)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else if (gate_mode == 2)
            while ($urandom_range(0, 2) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b1, vs, de);
    endtask

    // Active lines followed by the vs-edge cycle; returns right after that edge.
    task automatic frame(input int nlines, input int bad_line, input int bad_len,
                         input bit tight, input bit vs_de);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == bad_line) ? bad_len : H;
            for (int p = 0; p < len; p++) px(1'b1, 1'b1);
            if (!(tight && l == nlines - 1)) begin
                px(1'b1, 1'b0);
                px(1'b1, 1'b0);
            end
        end
        px(1'b0, vs_de);
    endtask

    task automatic vblank();
        px(1'b0, 1'b0);
        px(1'b1, 1'b0);
        px(1'b1, 1'b0);
    endtask

    task automatic good_frame();
        frame(V, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_rgb);
        bus.ce = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk_rgb);
        rst_n = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ce = 1'b0; bus.hs = 1'b1; bus.vs = 1'b1; bus.de = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_rgb);
        do_reset();

        // Clean lock: first edge only leaves SEARCH, two checked frames lock.
        gate_mode = 0;
        good_frame(); check("clean_f1_locked", bus.locked, 0); vblank();
        good_frame(); check("clean_f2_locked", bus.locked, 0); vblank();
        good_frame();
        check("clean_f3_locked", bus.locked, 1);
        check("clean_f3_fs", bus.frame_start, 1);
        check("clean_f3_err", bus.error, 0);
        vblank();

        // Short last line while locked.
        frame(V, V - 1, 3, 1'b0, 1'b0);
        check("short_err", bus.error, 1);
        check("short_locked", bus.locked, 0);
        if (MEAS) check("short_meas_w", bus.measured_width, 3);
        vblank();
        good_frame(); check("short_relock1", bus.locked, 0); vblank();
        good_frame(); check("short_relock2", bus.locked, 1); vblank();

        // Extra line.
        frame(V + 1, -1, 0, 1'b0, 1'b0);
        check("extra_err", bus.error, 1);
        if (MEAS) check("extra_meas_h", bus.measured_height, 4);
        vblank();
        good_frame(); vblank();
        good_frame(); check("extra_relock", bus.locked, 1); vblank();

        // ce alternating with noise on the idle cycles.
        do_reset();
        gate_mode = 1;
        good_frame(); vblank();
        good_frame(); check("ce_gate_f2_locked", bus.locked, 0); vblank();
        good_frame(); check("ce_gate_locked", bus.locked, 1); vblank();
        gate_mode = 0;

        // de falls on the vs-edge cycle: last line stays in the old frame.
        frame(V, -1, 0, 1'b1, 1'b0);
        check("coinc_fall_err", bus.error, 0);
        check("coinc_fall_locked", bus.locked, 1);
        vblank();

        // de high on the vs-edge cycle: pixel is line 0 of the new frame.
        frame(V, -1, 0, 1'b0, 1'b1);
        check("coinc_de_y", bus.y, 0);
        check("coinc_de_x", bus.x, 0);
        for (int p = 1; p < H; p++) px(1'b0, 1'b1);
        px(1'b1, 1'b0);
        px(1'b1, 1'b0);
        frame(V - 1, -1, 0, 1'b0, 1'b0);
        check("coinc_de_err", bus.error, 0);
        check("coinc_de_locked", bus.locked, 1);
        vblank();

        // Reset during line 1, then partial frame, then two good frames.
        for (int p = 0; p < H; p++) px(1'b1, 1'b1);
        px(1'b1, 1'b0);
        px(1'b1, 1'b0);
        px(1'b1, 1'b1);
        px(1'b1, 1'b1);
        do_reset();
        px(1'b1, 1'b1);
        check("rst_search_de_o", bus.de_o, 0);
        px(1'b1, 1'b1);
        px(1'b1, 1'b0);
        px(1'b1, 1'b0);
        for (int p = 0; p < H; p++) px(1'b1, 1'b1);
        px(1'b1, 1'b0);
        px(1'b0, 1'b0);
        check("rst_partial_err", bus.error, 0);
        px(1'b0, 1'b0);
        px(1'b1, 1'b0);
        good_frame(); check("rst_f1_locked", bus.locked, 0); vblank();
        good_frame(); check("rst_f2_locked", bus.locked, 1); vblank();

        // Randomized frames: geometry faults, ce gating, coincident events, resets.
        for (int f = 0; f < 80; f++) begin
            int nl, bl, blen;
            bit tight, vde;
            gate_mode = $urandom_range(0, 2);
            nl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : V;
            bl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            blen = $urandom_range(1, 9);
            tight = ($urandom_range(0, 3) == 0);
            vde   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) do_reset();
            frame(nl, bl, blen, tight, vde);
            vblank();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
